// File: rtl/usb_crc5_if.sv
// -----------------------------------------------------------------------------
// usb_crc5_if
//   Bundles the control, data and result signals of the USB token CRC5
//   generator.
//   Signals:
//     crc_clr  1  re-seed the CRC for a new token (active-high)
//     crc_en   1  fold data_in into the CRC this cycle
//     data_in  8  byte to fold, bit 0 first
//     crc_out  5  current complemented CRC field
//   Modports:
//     master : drives crc_clr/crc_en/data_in, observes crc_out (token path)
//     slave  : the CRC generator itself
// -----------------------------------------------------------------------------
interface usb_crc5_if;
  logic       crc_clr;
  logic       crc_en;
  logic [7:0] data_in;
  logic [4:0] crc_out;

  modport master (
    output crc_clr,
    output crc_en,
    output data_in,
    input  crc_out
  );

  modport slave (
    input  crc_clr,
    input  crc_en,
    input  data_in,
    output crc_out
  );
endinterface : usb_crc5_if

// File: rtl/usb_crc5_gen.sv
// -----------------------------------------------------------------------------
// usb_crc5_gen
//   Byte-serial USB token CRC5 generator: polynomial x^5+x^2+1, seed 5'b11111.
//   One byte per enabled clock is folded LSB first into a 5-bit register c;
//   the CRC field presented is the complement of that register.
//   Ports:
//     clk    in  1  rising-edge clock
//     n_rst  in  1  synchronous reset, ACTIVE-HIGH despite the legacy name
//     bus    slave modport of usb_crc5_if (crc_clr, crc_en, data_in, crc_out)
//   Configuration:
//     USB_CRC5_BITREV_EN  when defined, crc_out is bit-reversed so that
//                         crc_out[i] = ~c[4-i] (USB wire order, MSB first).
//                         The register and update math do not change.
// -----------------------------------------------------------------------------
module usb_crc5_gen (
  input logic          clk,
  input logic          n_rst,
  usb_crc5_if.slave    bus
);

  localparam logic [4:0] CRC5_SEED = 5'b11111;
  localparam logic [4:0] CRC5_POLY = 5'b00101;

  logic [4:0] c;

  // Eight serial LFSR steps unrolled into one combinational fold.
  function automatic logic [4:0] f8(input logic [4:0] c_in, input logic [7:0] d);
    logic [4:0] r;
    logic       fb;
    r = c_in;
    for (int i = 0; i < 8; i++) begin
      // NOTE: blocking assignments inside the function are intentional; each
      // bit step must see the result of the previous step within one cycle.
      fb = d[i] ^ r[4];
      r  = {r[3:0], 1'b0} ^ (fb ? CRC5_POLY : 5'b00000);
    end
    return r;
  endfunction

  // Priority: reset, then clear, then enable, otherwise hold.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments only.
    if (n_rst) begin
      c <= CRC5_SEED;
    end else if (bus.crc_clr) begin
      c <= CRC5_SEED;
    end else if (bus.crc_en) begin
      c <= f8(c, bus.data_in);
    end
  end

  // Output is a pure function of the register; no input reaches crc_out
  // combinationally.
`ifdef USB_CRC5_BITREV_EN
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      bus.crc_out[i] = ~c[4-i];
    end
  end
`else
  assign bus.crc_out = ~c;
`endif

endmodule : usb_crc5_gen

// File: tb/tb_usb_crc5_gen.sv
// -----------------------------------------------------------------------------
// tb_usb_crc5_gen
//   Scoreboard bench for usb_crc5_gen. The stimulus process drives one
//   operation per clock and pushes the expected crc_out; a monitor pops and
//   compares on the falling edge. The reference keeps every bit folded since
//   the last seed and derives the CRC by polynomial long division.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_usb_crc5_gen;

  logic tb_clk;
  logic n_rst;

  usb_crc5_if bus ();

  usb_crc5_gen dut (
    .clk   (tb_clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  typedef struct {
    logic [4:0] exp;
    string      name;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Bits folded since the last seed, in processing order.
  bit   msg_q[$];

  // CRC register value from polynomial division: remainder of
  // M(x)*x^5 + S(x)*x^n modulo x^5+x^2+1, seed S = 11111.
  function automatic logic [4:0] ref_c(input bit m[$]);
    int   n;
    bit   a[];
    bit   g[6];
    logic [4:0] r;
    g = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    n = m.size();
    if (n == 0) return 5'b11111;
    a = new[n + 5];
    for (int i = 0; i < n + 5; i++) a[i] = (i < n) ? m[i] : 1'b0;
    for (int i = 0; i < 5; i++) a[i] = a[i] ^ 1'b1;
    for (int i = 0; i < n; i++) begin
      if (a[i]) begin
        for (int j = 0; j < 6; j++) a[i+j] = a[i+j] ^ g[j];
      end
    end
    for (int i = 0; i < 5; i++) r[4-i] = a[n+i];
    return r;
  endfunction

  // Map a normal-order CRC field to what crc_out presents in this build.
  function automatic logic [4:0] to_out(input logic [4:0] f);
`ifdef USB_CRC5_BITREV_EN
    logic [4:0] r;
    for (int i = 0; i < 5; i++) r[i] = f[4-i];
    return r;
`else
    return f;
`endif
  endfunction

  // One clock of stimulus. If use_k is set, the hand-computed constant k
  // (normal order) is expected instead of the model's value.
  task automatic step(input bit rst, input bit clr, input bit en,
                      input logic [7:0] d, input string name,
                      input bit use_k, input logic [4:0] k);
    exp_t e;
    n_rst       = rst;
    bus.crc_clr = clr;
    bus.crc_en  = en;
    bus.data_in = en ? d : 8'hxx;
    @(posedge tb_clk);
    if (rst || clr) begin
      msg_q.delete();
    end else if (en) begin
      for (int i = 0; i < 8; i++) msg_q.push_back(d[i]);
    end
    e.exp  = use_k ? to_out(k) : to_out(~ref_c(msg_q));
    e.name = name;
    sb_q.push_back(e);
    #1;
  endtask

  // Monitor: compare one expected value per falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge tb_clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_cmp++;
        if (bus.crc_out !== e.exp) begin
          n_fail++;
          $display("FAIL %s: crc_out=%b expected=%b", e.name, bus.crc_out, e.exp);
        end
      end
    end
  end

  initial begin
    int r;
    int drain;
    logic [7:0] rb;
    logic [7:0] last_b;
    n_rst       = 1'b1;
    bus.crc_clr = 1'b0;
    bus.crc_en  = 1'b0;
    bus.data_in = 8'h00;
    @(negedge tb_clk);

    // Reset and hold
    step(1, 0, 0, 8'h00, "reset0", 1, 5'b00000);
    step(1, 0, 0, 8'h00, "reset1", 1, 5'b00000);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 8'h00, "hold_after_reset", 1, 5'b00000);

    // Two 0x00 bytes
    step(0, 0, 1, 8'h00, "byte00_first", 1, 5'b10000);
    step(0, 0, 1, 8'h00, "byte00_second", 1, 5'b11110);

    // 0xFF
    step(1, 0, 0, 8'h00, "reset_ff", 1, 5'b00000);
    step(0, 0, 1, 8'hFF, "byteFF", 1, 5'b00100);

    // 0xAA then clear+enable
    step(1, 0, 0, 8'h00, "reset_aa", 1, 5'b00000);
    step(0, 0, 1, 8'hAA, "byteAA", 1, 5'b11100);
    step(0, 1, 1, 8'hAA, "clr_beats_en", 1, 5'b00000);
    step(0, 0, 0, 8'h00, "hold_after_clr", 1, 5'b00000);

    // Mid-stream reset
    step(0, 0, 1, 8'hFF, "mid_ff", 1, 5'b00100);
    step(1, 0, 1, 8'h5A, "mid_reset", 1, 5'b00000);
    step(0, 0, 1, 8'h00, "after_mid_reset", 1, 5'b10000);

    // Reset beats clear and enable together
    step(1, 1, 1, 8'hC3, "reset_priority", 1, 5'b00000);

    // Constant byte with continuous enable
    rb = 8'($urandom);
    for (int i = 0; i < 6; i++) step(0, 0, 1, rb, "const_byte_stream", 0, 5'b00000);
    step(0, 0, 0, 8'h00, "const_byte_hold", 0, 5'b00000);

    // Randomized traffic
    last_b = 8'h00;
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 3) begin
        step(1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 8'($urandom),
             "rand_reset", 0, 5'b00000);
      end else if (r < 12) begin
        step(0, 1, $urandom_range(0, 1) == 1, 8'($urandom), "rand_clr", 0, 5'b00000);
      end else if (r < 72) begin
        if (r < 20) rb = last_b; else rb = 8'($urandom);
        last_b = rb;
        step(0, 0, 1, rb, "rand_byte", 0, 5'b00000);
      end else begin
        step(0, 0, 0, 8'h00, "rand_hold", 0, 5'b00000);
      end
    end

    drain = 0;
    while (sb_q.size() > 0 && drain < 10) begin
      @(posedge tb_clk);
      drain++;
    end
    @(posedge tb_clk);
    if (sb_q.size() > 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: pending=%0d required=0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_usb_crc5_gen
